// File: rtl/hc_univ_reg.sv
// Universal WIDTH-bit register: hold, shift, load, rotate and count modes.
// Provides serial-out and terminal-count outputs so instances can be cascaded.
module hc_univ_reg #(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             Clk,
    input  logic             R_N,
    input  logic             SCLR_N,
    input  logic             CE,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             DSU,
    input  logic             DSD,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_N,
    output logic             SO,
    output logic             TC
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHU  = 3'b001;
    localparam logic [2:0] MODE_SHD  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROTU = 3'b100;
    localparam logic [2:0] MODE_ROTD = 3'b101;
    localparam logic [2:0] MODE_CNTU = 3'b110;
    localparam logic [2:0] MODE_CNTD = 3'b111;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             so_reg;
    logic             so_next;

    always_comb begin
        q_next  = q_reg;
        so_next = so_reg;
        if (!SCLR_N) begin
            q_next  = RST_VAL;
            so_next = 1'b0;
        end else if (CE) begin
            case (Mode)
                MODE_HOLD: begin
                    q_next  = q_reg;
                    so_next = so_reg;
                end
                MODE_SHU: begin
                    q_next  = {q_reg[WIDTH-2:0], DSU};
                    so_next = q_reg[WIDTH-1];
                end
                MODE_SHD: begin
                    q_next  = {DSD, q_reg[WIDTH-1:1]};
                    so_next = q_reg[0];
                end
                MODE_LOAD: q_next = D;
                MODE_ROTU: begin
                    q_next  = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                    so_next = q_reg[WIDTH-1];
                end
                MODE_ROTD: begin
                    q_next  = {q_reg[0], q_reg[WIDTH-1:1]};
                    so_next = q_reg[0];
                end
                MODE_CNTU: q_next = q_reg + ONE;
                MODE_CNTD: q_next = q_reg - ONE;
                default: begin
                    q_next  = 'x;
                    so_next = 1'bx;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge R_N) begin
        if (!R_N) begin
            q_reg  <= RST_VAL;
            so_reg <= 1'b0;
        end else begin
            q_reg  <= q_next;
            so_reg <= so_next;
        end
    end

    // Q_N is derived from Q so the two can never disagree.
    assign Q   = q_reg;
    assign Q_N = ~q_reg;
    assign SO  = so_reg;
    assign TC  = CE & (((Mode == MODE_CNTU) & (q_reg == '1)) |
                       ((Mode == MODE_CNTD) & (q_reg == '0)));

endmodule

// File: tb/tb_hc_univ_reg.sv
// Directed bench for hc_univ_reg: an 8-bit instance plus a two-stage 4-bit cascade.
module tb_hc_univ_reg;

    logic       clk;
    logic       r_n, sclr_n, ce, dsu, dsd;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q, q_n;
    logic       so, tc;

    logic       c_rn;
    logic [2:0] c_mode;
    logic [3:0] c_d;
    logic [3:0] c_q_lo, c_q_hi, c_qn_lo, c_qn_hi;
    logic       c_so_lo, c_so_hi, c_tc_lo, c_tc_hi;

    int checks   = 0;
    int failures = 0;

    hc_univ_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut (
        .Clk(clk), .R_N(r_n), .SCLR_N(sclr_n), .CE(ce), .Mode(mode), .D(d),
        .DSU(dsu), .DSD(dsd), .Q(q), .Q_N(q_n), .SO(so), .TC(tc)
    );

    hc_univ_reg #(.WIDTH(4), .RST_VAL(4'hE)) u_lo (
        .Clk(clk), .R_N(c_rn), .SCLR_N(1'b1), .CE(1'b1), .Mode(c_mode), .D(c_d),
        .DSU(1'b0), .DSD(1'b0), .Q(c_q_lo), .Q_N(c_qn_lo), .SO(c_so_lo), .TC(c_tc_lo)
    );

    hc_univ_reg #(.WIDTH(4), .RST_VAL(4'h0)) u_hi (
        .Clk(clk), .R_N(c_rn), .SCLR_N(1'b1), .CE(c_tc_lo), .Mode(c_mode), .D(c_d),
        .DSU(1'b0), .DSD(1'b0), .Q(c_q_hi), .Q_N(c_qn_hi), .SO(c_so_hi), .TC(c_tc_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        ce = 1'b1; mode = 3'b011; d = val;
        step();
    endtask

    task automatic test_reset();
        r_n = 1'b1; sclr_n = 1'b1; ce = 1'b0; mode = 3'b000; d = 8'h00; dsu = 1'b0; dsd = 1'b0;
        #1 r_n = 1'b0;
        #2;
        checks++;
        if (q !== 8'hA5 || q_n !== 8'h5A || so !== 1'b0) begin
            failures++;
            $display("FAIL reset_init q=%h q_n=%h so=%b required q=a5 q_n=5a so=0", q, q_n, so);
        end
        step();
        r_n = 1'b1;
        load(8'hC3);
        mode = 3'b001; dsu = 1'b0;
        step();
        checks++;
        if (q !== 8'h86 || so !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_shift q=%h so=%b required q=86 so=1", q, so);
        end
        #2 r_n = 1'b0;
        #1;
        checks++;
        if (q !== 8'hA5 || q_n !== 8'h5A || so !== 1'b0) begin
            failures++;
            $display("FAIL async_reset q=%h q_n=%h so=%b required q=a5 q_n=5a so=0", q, q_n, so);
        end
        step();
        checks++;
        if (q !== 8'hA5) begin
            failures++;
            $display("FAIL reset_held q=%h required a5", q);
        end
        r_n = 1'b1;
        $display("test_reset done q=%h q_n=%h so=%b", q, q_n, so);
    endtask

    task automatic test_load_shift();
        load(8'h81);
        checks++;
        if (q !== 8'h81 || q_n !== 8'h7E) begin
            failures++;
            $display("FAIL load q=%h q_n=%h required q=81 q_n=7e", q, q_n);
        end
        mode = 3'b001; dsu = 1'b0;
        step();
        checks++;
        if (q !== 8'h02 || so !== 1'b1) begin
            failures++;
            $display("FAIL shift_up q=%h so=%b required q=02 so=1", q, so);
        end
        mode = 3'b010; dsd = 1'b1;
        step();
        checks++;
        if (q !== 8'h81 || so !== 1'b0) begin
            failures++;
            $display("FAIL shift_down q=%h so=%b required q=81 so=0", q, so);
        end
        $display("test_load_shift done q=%h so=%b", q, so);
    endtask

    task automatic test_rotate();
        logic [7:0] exp_q [8];
        exp_q = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        load(8'h01);
        mode = 3'b101;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (q !== exp_q[i] || so !== (i == 0)) begin
                failures++;
                $display("FAIL rotate_down[%0d] q=%h so=%b required q=%h so=%b", i, q, so, exp_q[i], i == 0);
            end
        end
        mode = 3'b100;
        step();
        checks++;
        if (q !== 8'h02 || so !== 1'b0) begin
            failures++;
            $display("FAIL rotate_up q=%h so=%b required q=02 so=0", q, so);
        end
        load(8'h80);
        mode = 3'b100;
        step();
        checks++;
        if (q !== 8'h01 || so !== 1'b1) begin
            failures++;
            $display("FAIL rotate_up_wrap q=%h so=%b required q=01 so=1", q, so);
        end
        $display("test_rotate done q=%h so=%b", q, so);
    endtask

    task automatic test_count_wrap();
        load(8'hFE);
        mode = 3'b110;
        step();
        checks++;
        if (q !== 8'hFF || tc !== 1'b1) begin
            failures++;
            $display("FAIL count_up_ff q=%h tc=%b required q=ff tc=1", q, tc);
        end
        step();
        checks++;
        if (q !== 8'h00 || tc !== 1'b0) begin
            failures++;
            $display("FAIL count_up_wrap q=%h tc=%b required q=00 tc=0", q, tc);
        end
        load(8'h01);
        mode = 3'b111;
        step();
        checks++;
        if (q !== 8'h00 || tc !== 1'b1) begin
            failures++;
            $display("FAIL count_down_00 q=%h tc=%b required q=00 tc=1", q, tc);
        end
        step();
        checks++;
        if (q !== 8'hFF || tc !== 1'b0) begin
            failures++;
            $display("FAIL count_down_wrap q=%h tc=%b required q=ff tc=0", q, tc);
        end
        mode = 3'b110;
        #1;
        checks++;
        if (tc !== 1'b1) begin
            failures++;
            $display("FAIL tc_mode_switch tc=%b required 1", tc);
        end
        $display("test_count_wrap done q=%h tc=%b", q, tc);
    endtask

    task automatic test_priority();
        load(8'h81);
        mode = 3'b001; dsu = 1'b1;
        step();
        checks++;
        if (q !== 8'h03 || so !== 1'b1) begin
            failures++;
            $display("FAIL prio_setup q=%h so=%b required q=03 so=1", q, so);
        end
        load(8'hFF);
        ce = 1'b1; mode = 3'b000;
        step();
        checks++;
        if (q !== 8'hFF || so !== 1'b1 || tc !== 1'b0) begin
            failures++;
            $display("FAIL hold q=%h so=%b tc=%b required q=ff so=1 tc=0", q, so, tc);
        end
        ce = 1'b0; mode = 3'b110;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (q !== 8'hFF || so !== 1'b1 || tc !== 1'b0) begin
                failures++;
                $display("FAIL ce_off[%0d] q=%h so=%b tc=%b required q=ff so=1 tc=0", i, q, so, tc);
            end
        end
        sclr_n = 1'b0;
        step();
        checks++;
        if (q !== 8'hA5 || q_n !== 8'h5A || so !== 1'b0) begin
            failures++;
            $display("FAIL sync_clear q=%h q_n=%h so=%b required q=a5 q_n=5a so=0", q, q_n, so);
        end
        sclr_n = 1'b1;
        $display("test_priority done q=%h so=%b", q, so);
    endtask

    task automatic test_cascade();
        c_mode = 3'b110; c_d = 4'h0;
        #2 c_rn = 1'b1;
        step();
        step();
        checks++;
        if ({c_q_hi, c_q_lo} !== 8'h10) begin
            failures++;
            $display("FAIL cascade_2 value=%h required 10", {c_q_hi, c_q_lo});
        end
        for (int i = 0; i < 15; i++) step();
        checks++;
        if ({c_q_hi, c_q_lo} !== 8'h1F || c_tc_lo !== 1'b1) begin
            failures++;
            $display("FAIL cascade_17 value=%h tc_lo=%b required 1f tc_lo=1", {c_q_hi, c_q_lo}, c_tc_lo);
        end
        step();
        checks++;
        if ({c_q_hi, c_q_lo} !== 8'h20) begin
            failures++;
            $display("FAIL cascade_18 value=%h required 20", {c_q_hi, c_q_lo});
        end
        $display("test_cascade done value=%h", {c_q_hi, c_q_lo});
    endtask

    initial begin
        c_rn = 1'b0; c_mode = 3'b000; c_d = 4'h0;
        test_reset();
        test_load_shift();
        test_rotate();
        test_count_wrap();
        test_priority();
        test_cascade();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
